pong_spi_slave: RTL and testbench
=================================

PONG_SPI_SLAVE -- requirements
Module: pong_spi_slave

Interface
REQ-001 Parameter WIDTH, default 8, frame length in bits (range 4..16).
REQ-002 Parameter IDLE_BYTE, default 0, WIDTH-bit word shifted out on MISO when no transmit word is buffered.
REQ-003 clk_clk  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-004 reset_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_slave_SCLK  input  1  external master serial clock; SPI mode 0 (CPOL=0, CPHA=0); asynchronous to clk_clk.
REQ-006 spi_slave_MOSI  input  1  serial data from the master, MSB first.
REQ-007 spi_slave_SS_n  input  1  active-low slave select from the master.
REQ-008 spi_slave_MISO  output  1  serial data to the master, MSB first.
REQ-009 tx_data  input  WIDTH  word to return in a later frame.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  high when the transmit holding register is empty.
REQ-012 rx_data  output  WIDTH  last complete received frame.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 frame_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-015 SCLK, MOSI and SS_n SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies plus a third registered SCLK copy for edge detection.
REQ-016 Operating limit: SCLK high time and low time each ≥3 clk_clk periods; SS_n setup to the first SCLK rise ≥3 clk_clk periods.
REQ-017 FSM states: IDLE (SS_n high) and SHIFT (SS_n low).
REQ-018 IDLE->SHIFT on the synchronized SS_n falling edge; in that cycle: bit_cnt <- 0, and the shift-out register loads the holding register if full (holding register becomes empty), otherwise IDLE_BYTE.
REQ-019 SHIFT->IDLE whenever synchronized SS_n is high; bit_cnt <- 0; if bit_cnt != 0, frame_err pulses for one cycle and partial received bits are discarded (rx_data unchanged, no rx_valid).
REQ-020 In SHIFT, on a detected SCLK rise: the receive register shifts left, taking MOSI into the LSB; bit_cnt increments.
REQ-021 When a rise makes bit_cnt reach WIDTH: rx_data <- the completed word; rx_valid pulses on the next clk_clk edge; bit_cnt <- 0; the shift-out register reloads per the REQ-018 rule.
REQ-022 In SHIFT, on a detected SCLK fall with bit_cnt != 0, the shift-out register shifts left by one; a fall with bit_cnt == 0 SHALL NOT shift, so a reloaded word is not corrupted.
REQ-023 spi_slave_MISO SHALL equal the shift-out register MSB in SHIFT and 0 in IDLE.
REQ-024 rx_valid latency: asserted on the 4th clk_clk rising edge after the edge that first samples the WIDTH-th SCLK rise at the pin.
REQ-025 Back-to-back frames with SS_n held low SHALL be supported with no gap bits.
REQ-026 Holding register capture: when tx_valid and tx_ready are both high, capture tx_data; tx_ready goes low on the next cycle; tx_data is ignored while tx_ready is low.
REQ-027 Capture and reload in the same cycle with an empty holding register: the shift-out register loads IDLE_BYTE and the holding register captures tx_data, which is used in the next frame (no bypass).
REQ-028 A synchronized SS_n rise and the WIDTH-th SCLK rise detected in the same cycle: the abort takes priority (frame_err, no rx_valid).
REQ-029 There is no receive backpressure; the consumer must take rx_data within WIDTH SCLK periods.

Reset
REQ-030 While reset_reset_n is low, the block SHALL hold these values:
- State IDLE, bit_cnt 0.
- Synchronizer flops: SCLK 0, MOSI 0, SS_n 1.
- Shift registers 0; holding register empty.
- Outputs: tx_ready 1, rx_data 0, rx_valid 0, frame_err 0, spi_slave_MISO 0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately with no rx_valid or frame_err pulse; after release, the block waits for a fresh SS_n falling edge.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset, then clk 50 MHz, SCLK 1 MHz, master sends 0xA5 -> rx_data=0xA5, exactly one rx_valid pulse, MISO bits = 0x00.
- tx_data=0x3C loaded before SS_n falls, master sends 0xFF -> MISO bits 0x3C, rx_data=0xFF, tx_ready back to 1 at frame start.
- SS_n held low for 3 frames 0x01,0x02,0x03 with 0x11 and 0x22 queued one at a time -> rx_valid pulses 3 times with data in order; MISO returns 0x11,0x22,0x00.
- SS_n raised after 5 SCLK rises -> one frame_err pulse, rx_data unchanged, next full frame 0x5A received correctly.
- reset_reset_n pulsed low after 4 bits -> all outputs at reset values, no pulses; next frame 0xC3 received correctly.
- tx_valid asserted in the SS_n-fall reload cycle with the holding register empty -> frame returns 0x00 and the next frame returns the captured word.

Source files
------------

// File: rtl/pong_spi_slave.sv
`timescale 1ns/1ps
// pong_spi_slave: SPI mode-0 slave, oversampled by clk_clk.
// SCLK, MOSI and SS_n are synchronized. Received frames are presented on
// rx_data/rx_valid. A single holding register supplies the word that is
// returned on MISO in the next frame, and IDLE_BYTE is sent when it is empty.
module pong_spi_slave #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_BYTE = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             spi_slave_SCLK,
    input  logic             spi_slave_MOSI,
    input  logic             spi_slave_SS_n,
    output logic             spi_slave_MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;
    logic ss_s1, ss_s2;

    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             word_done;
    logic             data_new;

    logic sclk_rise, sclk_fall;
    logic start, leave, abort, rise_ok, fall_ok;
    logic last_bit, reload, capture;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;

    // Synchronize the SPI pins into the clk_clk domain; third SCLK stage for edges.
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the pre-edge values and the synchronizer chain shifts one stage per clock.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
        end else begin
            sclk_s1 <= spi_slave_SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= spi_slave_MOSI;
            mosi_s2 <= mosi_s1;
            ss_s1   <= spi_slave_SS_n;
            ss_s2   <= ss_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes. SS_n high always wins over SCLK
    // edges, so a rise seen together with the deselect counts as an abort.
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        leave      = 1'b0;
        abort      = 1'b0;
        rise_ok    = 1'b0;
        fall_ok    = 1'b0;
        case (state)
            IDLE: begin
                // In IDLE the synchronized SS_n was high, so low here is a falling edge.
                if (!ss_s2) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_s2) begin
                    state_next = IDLE;
                    leave      = 1'b1;
                    abort      = (bit_cnt != '0);
                end else begin
                    rise_ok = sclk_rise;
                    fall_ok = sclk_fall && (bit_cnt != '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign last_bit = rise_ok && (bit_cnt == LAST_BIT);
    assign reload   = start | last_bit;
    assign capture  = tx_valid & ~hold_full;

    // Bit counter, receive/transmit shift registers and holding register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            if (leave || start || last_bit) begin
                bit_cnt <= '0;
            end else if (rise_ok) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (rise_ok) begin
                rx_shift <= {rx_shift[WIDTH-2:0], mosi_s2};
            end

            // A reload takes the buffered word if present; a capture in the same
            // cycle only fills the holding register for the following frame.
            if (reload) begin
                tx_shift <= hold_full ? hold_data : IDLE_BYTE;
            end else if (fall_ok) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end

            if (reload && hold_full) begin
                hold_full <= 1'b0;
            end else if (capture) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    // Frame completion pipeline: publish rx_data one cycle after the last bit,
    // then pulse rx_valid the cycle after that; aborts pulse frame_err.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            word_done <= 1'b0;
            data_new  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= last_bit;
            data_new  <= word_done;
            rx_valid  <= data_new;
            frame_err <= abort;
            if (word_done) begin
                rx_data <= rx_shift;
            end
        end
    end

    assign tx_ready       = ~hold_full;
    assign spi_slave_MISO = (state == SHIFT) & tx_shift[WIDTH-1];

endmodule

// File: tb/tb_pong_spi_slave.sv
`timescale 1ns/1ps
// Bench for pong_spi_slave: 50 MHz clk_clk, 1 MHz SPI master model.
// Expected receive words and MISO words go into scoreboard queues when a frame
// is driven; a negedge monitor pops them when rx_valid appears.
module tb_pong_spi_slave;

    localparam int HALF = 500;  // SCLK half period in ns

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, mosi, ss_n, miso;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  rx_cnt   = 0;
    int  err_cnt  = 0;
    time last_rise_t = 0;

    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];

    pong_spi_slave #(.WIDTH(8), .IDLE_BYTE(8'h00)) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .spi_slave_SCLK (sclk),
        .spi_slave_MOSI (mosi),
        .spi_slave_SS_n (ss_n),
        .spi_slave_MISO (miso),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .frame_err      (frame_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Monitor: score every rx_valid pulse and count frame_err pulses.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            check("rx_latency", 32'($time - last_rise_t), 32'd100);
            if (rx_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else check("rx_data", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
        end
        if (frame_err) err_cnt++;
    end

    task automatic ss_low();
        ss_n = 1'b0;
        #HALF;
    endtask

    task automatic ss_high();
        #HALF;
        ss_n = 1'b1;
        #(2 * HALF);
    endtask

    // Master shifts nbits of w out MSB first; full frames are scoreboarded.
    task automatic xfer(input logic [7:0] w, input int nbits, input logic [7:0] miso_exp);
        logic [7:0] got;
        got = '0;
        if (nbits == 8) begin
            rx_q.push_back(w);
            miso_q.push_back(miso_exp);
        end
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7 - i];
            #HALF;
            sclk = 1'b1;
            got = {got[6:0], miso};
            if (i == nbits - 1) last_rise_t = $time;
            #HALF;
            sclk = 1'b0;
        end
        if (nbits == 8) check("miso_word", {24'd0, got}, {24'd0, miso_q.pop_front()});
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_ready",  {31'd0, tx_ready},  32'd1);
        check("rst_rx_data",   {24'd0, rx_data},   32'd0);
        check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_miso",      {31'd0, miso},      32'd0);
    endtask

    initial begin
        int rx0, err0;
        rst_n    = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        ss_n     = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain frame, nothing buffered: MISO returns IDLE_BYTE.
        rx0 = rx_cnt; err0 = err_cnt;
        ss_low();
        xfer(8'hA5, 8, 8'h00);
        ss_high();
        check("s1_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("s1_err_pulses", 32'(err_cnt - err0), 32'd0);

        // Buffered word is returned; holding register empties at frame start.
        load_tx(8'h3C);
        rx0 = rx_cnt;
        ss_low();
        check("s2_tx_ready_start", {31'd0, tx_ready}, 32'd1);
        xfer(8'hFF, 8, 8'h3C);
        ss_high();
        check("s2_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

        // Three back-to-back frames; second word queued mid-frame.
        load_tx(8'h11);
        rx0 = rx_cnt;
        ss_low();
        fork
            xfer(8'h01, 8, 8'h11);
            begin
                #2000;
                load_tx(8'h22);
            end
        join
        xfer(8'h02, 8, 8'h22);
        xfer(8'h03, 8, 8'h00);
        ss_high();
        check("s3_rx_pulses", 32'(rx_cnt - rx0), 32'd3);

        // Abort after 5 bits, then a clean frame.
        rx0 = rx_cnt; err0 = err_cnt;
        ss_low();
        xfer(8'hE7, 5, 8'h00);
        ss_high();
        check("s4_err_pulses", 32'(err_cnt - err0), 32'd1);
        check("s4_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
        check("s4_rx_kept", {24'd0, rx_data}, 32'h03);
        ss_low();
        xfer(8'h5A, 8, 8'h00);
        ss_high();
        check("s4_rx_after", 32'(rx_cnt - rx0), 32'd1);

        // Reset mid-frame after 4 bits.
        rx0 = rx_cnt; err0 = err_cnt;
        ss_low();
        xfer(8'h9F, 4, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("s5_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
        check("s5_err_pulses", 32'(err_cnt - err0), 32'd0);
        ss_low();
        xfer(8'hC3, 8, 8'h00);
        ss_high();
        check("s5_rx_after", {24'd0, rx_data}, 32'hC3);

        // tx_valid lands exactly on the SS_n-fall reload cycle.
        @(negedge clk);
        ss_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("s6_tx_ready_cap", {31'd0, tx_ready}, 32'd0);
        #HALF;
        xfer(8'h77, 8, 8'h00);
        xfer(8'h88, 8, 8'h96);
        ss_high();
        check("s6_tx_ready_end", {31'd0, tx_ready}, 32'd1);

        check("rx_queue_empty", 32'(rx_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
